// File: rtl/mmio_bridge.sv
// -----------------------------------------------------------------------------
// mmio_bridge
//
// Memory-mapped I/O bridge sitting on the single memory port of the
// multicycle RV32I CPU. It decodes the CPU byte address and does one of three
// things with each access:
//   - forwards it to an external word RAM (low region),
//   - serves it from a small peripheral block (GPIO, timer, console FIFO), or
//   - flags it as unmapped (reads 0; a write pulses bus_err next cycle).
//
// Read data is purely combinational from addr and current register state, so
// the CPU can latch it on the same edge exactly as it does with plain RAM.
// Reads never have side effects; the CPU may hold addr for several cycles.
//
// Peripheral register map (word registers, addr[1:0] ignored):
//   0xFFFF_0000  GPIO    RW  drives gpio_out
//   0xFFFF_0004  TCOUNT  RW  free-running up counter; a write loads it
//   0xFFFF_0008  TCMP    RW  compare value
//   0xFFFF_000C  TSTAT   bit0 match flag, write 1 to bit0 clears
//   0xFFFF_0010  CDATA   W   pushes wdata[7:0] into the console FIFO; reads 0
//   0xFFFF_0014  CSTAT   bit0 full, bit1 empty, bit2 overflow (sticky, W1C),
//                        bits[14:8] occupancy count
//
// Ports:
//   clk        system clock, all state on rising edge
//   reset      synchronous, active-high
//   addr       CPU byte address
//   wdata      CPU store data
//   we         CPU write enable; each high cycle is one full-word write
//   rdata      combinational read data back to the CPU
//   ram_addr   RAM word address (addr[RAM_ADDR_BITS-1:2])
//   ram_wdata  RAM write data (= wdata)
//   ram_we     RAM write enable (we qualified by RAM region hit)
//   ram_rdata  combinational RAM read data
//   gpio_out   GPIO output register
//   timer_irq  timer match flag
//   con_data   console FIFO head byte (0 when empty)
//   con_valid  console FIFO non-empty
//   con_ready  consumer accepts the head byte when con_valid is also high
//   bus_err    one-cycle pulse after a write to an unmapped address
// -----------------------------------------------------------------------------
module mmio_bridge #(
   parameter int FIFO_DEPTH    = 8,   // power of two, 2..64
   parameter int RAM_ADDR_BITS = 16   // byte-address bits of the RAM region
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [31:0]              addr,
   input  logic [31:0]              wdata,
   input  logic                     we,
   output logic [31:0]              rdata,
   output logic [RAM_ADDR_BITS-3:0] ram_addr,
   output logic [31:0]              ram_wdata,
   output logic                     ram_we,
   input  logic [31:0]              ram_rdata,
   output logic [31:0]              gpio_out,
   output logic                     timer_irq,
   output logic [7:0]               con_data,
   output logic                     con_valid,
   input  logic                     con_ready,
   output logic                     bus_err
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Register index = addr[4:2] within the 0xFFFF_0000 peripheral page.
   localparam logic [2:0] REG_GPIO   = 3'd0;
   localparam logic [2:0] REG_TCOUNT = 3'd1;
   localparam logic [2:0] REG_TCMP   = 3'd2;
   localparam logic [2:0] REG_TSTAT  = 3'd3;
   localparam logic [2:0] REG_CDATA  = 3'd4;
   localparam logic [2:0] REG_CSTAT  = 3'd5;

   // 0xFFFF_0000 >> 5: the 32-byte block holding all peripheral registers.
   localparam logic [26:0] PERIPH_BLOCK = 27'h7FF_F800;

   // ---------------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------------
   logic       ram_hit;
   logic       periph_hit;
   logic [2:0] reg_sel;

   assign ram_hit    = (addr[31:RAM_ADDR_BITS] == '0);
   assign reg_sel    = addr[4:2];
   assign periph_hit = (addr[31:5] == PERIPH_BLOCK) && (reg_sel <= REG_CSTAT);

   // Byte-lane bits are meaningless for word registers and word RAM.
   logic unused_addr_bits;
   assign unused_addr_bits = ^addr[1:0];

   logic wr_periph;
   logic wr_gpio;
   logic wr_tcount;
   logic wr_tcmp;
   logic wr_tstat;
   logic wr_cdata;
   logic wr_cstat;
   logic wr_unmapped;

   assign wr_periph   = we && periph_hit;
   assign wr_gpio     = wr_periph && (reg_sel == REG_GPIO);
   assign wr_tcount   = wr_periph && (reg_sel == REG_TCOUNT);
   assign wr_tcmp     = wr_periph && (reg_sel == REG_TCMP);
   assign wr_tstat    = wr_periph && (reg_sel == REG_TSTAT);
   assign wr_cdata    = wr_periph && (reg_sel == REG_CDATA);
   assign wr_cstat    = wr_periph && (reg_sel == REG_CSTAT);
   assign wr_unmapped = we && !ram_hit && !periph_hit;

   // ---------------------------------------------------------------------------
   // RAM pass-through
   // ---------------------------------------------------------------------------
   assign ram_addr  = addr[RAM_ADDR_BITS-1:2];
   assign ram_wdata = wdata;
   assign ram_we    = we && ram_hit;

   // ---------------------------------------------------------------------------
   // GPIO
   // ---------------------------------------------------------------------------
   // NOTE: clocked state is always assigned with <= so every register samples
   // the pre-edge values of its neighbours, independent of block ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         gpio_out <= '0;
      end else if (wr_gpio) begin
         gpio_out <= wdata;
      end
   end

   // ---------------------------------------------------------------------------
   // Timer: free-running counter, compare register and sticky match flag
   // ---------------------------------------------------------------------------
   logic [31:0] tcount;
   logic [31:0] tcmp;
   logic        tflag;
   logic        tmatch;
   logic        tflag_clr;

   // The match compares the values present this cycle, so a load of TCOUNT
   // on the matching edge still sets the flag.
   assign tmatch    = (tcount == tcmp);
   assign tflag_clr = wr_tstat && wdata[0];

   always_ff @(posedge clk) begin
      if (reset) begin
         tcount <= '0;
         tcmp   <= '1;
         tflag  <= 1'b0;
      end else begin
         // A software load overrides the increment; wrap is natural 32-bit.
         tcount <= wr_tcount ? wdata : tcount + 32'd1;
         if (wr_tcmp) begin
            tcmp <= wdata;
         end
         // Set has priority over a simultaneous write-1-to-clear.
         tflag <= tmatch || (tflag && !tflag_clr);
      end
   end

   assign timer_irq = tflag;

   // ---------------------------------------------------------------------------
   // Console FIFO
   // ---------------------------------------------------------------------------
   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;
   logic             push;
   logic             overflow;

   assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (count == '0);
   assign pop        = !fifo_empty && con_ready;
   // A full FIFO still takes a push when the head leaves on the same edge.
   assign push       = wr_cdata && (!fifo_full || pop);

   // NOTE: the storage array has no reset; only pointers and count do, and
   // con_data is forced to 0 while empty, so stale entries are never visible.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= wdata[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         // Pointers are PTR_W bits wide, so they wrap modulo FIFO_DEPTH.
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push) begin
            count <= count - CNT_W'(1);
         end
         // A dropped push sets the sticky flag; set beats a same-cycle clear.
         if (wr_cdata && !push) begin
            overflow <= 1'b1;
         end else if (wr_cstat && wdata[2]) begin
            overflow <= 1'b0;
         end
      end
   end

   assign con_valid = !fifo_empty;
   assign con_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

   // ---------------------------------------------------------------------------
   // Bus error: registered so it appears exactly one cycle after the write
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         bus_err <= 1'b0;
      end else begin
         bus_err <= wr_unmapped;
      end
   end

   // ---------------------------------------------------------------------------
   // Read mux
   // ---------------------------------------------------------------------------
   logic [31:0] cstat_value;

   assign cstat_value = {17'd0, 7'(count), 5'd0, overflow, fifo_empty, fifo_full};

   // NOTE: rdata gets a default before any branch so no path through this
   // block leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      rdata = '0;
      if (ram_hit) begin
         rdata = ram_rdata;
      end else if (periph_hit) begin
         case (reg_sel)
            REG_GPIO:   rdata = gpio_out;
            REG_TCOUNT: rdata = tcount;
            REG_TCMP:   rdata = tcmp;
            REG_TSTAT:  rdata = {31'd0, tflag};
            REG_CSTAT:  rdata = cstat_value;
            default:    rdata = '0;   // CDATA reads as zero
         endcase
      end
   end

endmodule
